// File: rtl/ecc_bus_pkg.sv
// Shared memory-bus types: packet kinds, bus identifiers, addresses and the
// packet struct carried between requesters and memory-side responders.
package ecc_bus_pkg;

    typedef enum logic [1:0] {
        bus_read_request   = 2'd0,
        bus_read_response  = 2'd1,
        bus_write_request  = 2'd2,
        bus_error_response = 2'd3
    } bus_packet_type_t;

    typedef logic [15:0] bus_id_t;
    typedef logic [63:0] memory_address_t;
    typedef logic [63:0] fetched_instruction_data_t;

    localparam logic [7:0] COMPONENT_TYPE_FETCH = 8'h01;

    typedef struct packed {
        bus_packet_type_t pkt_type;
        memory_address_t  address;
        bus_id_t          bus_id;
    } bus_packet_t;

    // A BusID is the owning core in the upper byte and the component kind below it.
    function automatic bus_id_t create_bus_id(input logic [7:0] core_id,
                                              input logic [7:0] component_type);
        return {core_id, component_type};
    endfunction

endpackage

// File: rtl/fetch_req_fifo.sv
// Request queue in front of the fetch responder. Pointers carry one extra wrap
// bit so full and empty are distinguished without a separate occupancy count.
module fetch_req_fifo
    import ecc_bus_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic        pop,
    input  bus_packet_t push_data,
    output bus_packet_t head_data,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    bus_packet_t entries [DEPTH];

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_data = entries[rd_ptr_q[AW-1:0]];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop && !empty) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // NOTE: state flops use non-blocking assignments so all of them update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push && !full) entries[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fetch_memory_responder.sv
// Memory-side responder for fetch reads: queues requests, waits a fixed access
// latency, then holds one response until the requester consumes it.
module fetch_memory_responder
    import ecc_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3,
    parameter int REQ_FIFO    = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [1:0]                     req_type,
    input  logic [63:0]                    req_address,
    input  logic [15:0]                    req_bus_id,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [1:0]                     resp_type,
    output logic [15:0]                    resp_bus_id,
    output logic [63:0]                    resp_payload,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_index,
    input  logic [63:0]                    load_data,
    output logic [15:0]                    err_count
);

    localparam int IW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RESPOND = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    bus_packet_t      cur_q, cur_d;
    logic             resp_valid_q, resp_valid_d;
    bus_packet_type_t resp_type_q, resp_type_d;
    bus_id_t          resp_bus_id_q, resp_bus_id_d;
    logic [63:0]      resp_payload_q, resp_payload_d;
    logic [15:0]      err_count_q, err_count_d;

    bus_packet_t in_pkt, head_pkt, next_pkt;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic        req_fire, have_next, take_next, access_ok;
    logic [63:0] rd_word;
    logic        unused_addr_bits;

    logic [63:0] store_mem [DEPTH_WORDS];

    assign req_ready = reset_n && !fifo_full;
    assign req_fire  = req_valid && req_ready;

    assign in_pkt.pkt_type = bus_packet_type_t'(req_type);
    assign in_pkt.address  = req_address;
    assign in_pkt.bus_id   = req_bus_id;

    fetch_req_fifo #(.DEPTH(REQ_FIFO)) u_req_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data (in_pkt),
        .head_data (head_pkt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The requester aligns addresses, so the byte offset carries no information.
    assign unused_addr_bits = ^cur_q.address[2:0];
    assign rd_word   = store_mem[cur_q.address[IW+2:3]];
    assign access_ok = (cur_q.pkt_type == bus_read_request) &&
                       (cur_q.address[63:3] < 61'(DEPTH_WORDS));

    always_ff @(posedge clk) begin
        if (load_en) store_mem[load_index] <= load_data;
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cur_d          = cur_q;
        resp_valid_d   = resp_valid_q;
        resp_type_d    = resp_type_q;
        resp_bus_id_d  = resp_bus_id_q;
        resp_payload_d = resp_payload_q;
        err_count_d    = err_count_q;
        fifo_push      = req_fire;
        fifo_pop       = 1'b0;
        take_next      = 1'b0;
        // With an empty queue the request arriving this cycle is taken straight
        // into service, so an idle responder answers exactly LATENCY cycles later.
        have_next      = !fifo_empty || req_fire;
        next_pkt       = fifo_empty ? in_pkt : head_pkt;

        case (state_q)
            ST_IDLE: take_next = have_next;
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    resp_valid_d  = 1'b1;
                    resp_bus_id_d = cur_q.bus_id;
                    state_d       = ST_RESPOND;
                    if (access_ok) begin
                        resp_type_d    = bus_read_response;
                        resp_payload_d = rd_word;
                    end else begin
                        resp_type_d    = bus_error_response;
                        resp_payload_d = '0;
                        if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESPOND: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    take_next    = have_next;
                    if (!have_next) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (take_next) begin
            cur_d    = next_pkt;
            cnt_d    = 4'(LATENCY - 1);
            state_d  = ST_ACCESS;
            fifo_pop = !fifo_empty;
            if (fifo_empty) fifo_push = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            cur_q          <= '0;
            resp_valid_q   <= 1'b0;
            resp_type_q    <= bus_read_request;
            resp_bus_id_q  <= '0;
            resp_payload_q <= '0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cur_q          <= cur_d;
            resp_valid_q   <= resp_valid_d;
            resp_type_q    <= resp_type_d;
            resp_bus_id_q  <= resp_bus_id_d;
            resp_payload_q <= resp_payload_d;
            err_count_q    <= err_count_d;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_type    = resp_type_q;
    assign resp_bus_id  = resp_bus_id_q;
    assign resp_payload = resp_payload_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_fetch_memory_responder.sv
// Scoreboard bench for fetch_memory_responder: stimulus queues expected
// responses, a negedge monitor compares each consumed response in order.
module tb_fetch_memory_responder;
    import ecc_bus_pkg::*;

    localparam int LAT = 3;
    localparam logic [63:0] W5 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] W6 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] W7 = 64'hA5A5_5A5A_0F0F_F0F0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready;
    logic [1:0]  req_type;
    logic [63:0] req_address;
    logic [15:0] req_bus_id;
    logic        resp_valid, resp_ready;
    logic [1:0]  resp_type;
    logic [15:0] resp_bus_id;
    logic [63:0] resp_payload;
    logic        load_en;
    logic [9:0]  load_index;
    logic [63:0] load_data;
    logic [15:0] err_count;

    typedef struct {
        logic [1:0]  t;
        logic [15:0] id;
        logic [63:0] p;
    } exp_t;

    exp_t exp_q[$];
    int   resp_cyc[$];
    int   n_resp = 0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    fetch_memory_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT), .REQ_FIFO(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_type     (req_type),
        .req_address  (req_address),
        .req_bus_id   (req_bus_id),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_type    (resp_type),
        .resp_bus_id  (resp_bus_id),
        .resp_payload (resp_payload),
        .load_en      (load_en),
        .load_index   (load_index),
        .load_data    (load_data),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a response is compared in the cycle the requester consumes it.
    always @(negedge clk) begin
        if (reset_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got id %h with no outstanding request", resp_bus_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_type", 64'(resp_type), 64'(e.t));
                check("resp_bus_id", 64'(resp_bus_id), 64'(e.id));
                check("resp_payload", resp_payload, e.p);
            end
            n_resp++;
            resp_cyc.push_back(cyc);
        end
    end

    task automatic issue(input logic [1:0] t, input logic [63:0] a, input logic [15:0] id,
                         input logic [1:0] et, input logic [63:0] ep, output int acc_cyc);
        logic ok;
        logic done;
        done = 1'b0;
        exp_q.push_back('{t: et, id: id, p: ep});
        req_valid   = 1'b1;
        req_type    = t;
        req_address = a;
        req_bus_id  = id;
        for (int i = 0; i < 50 && !done; i++) begin
            ok = req_ready;
            @(posedge clk);
            if (ok) done = 1'b1;
        end
        #1;
        acc_cyc = cyc;
        check("req_accept", 64'(done), 64'd1);
    endtask

    task automatic wait_valid(output int at_cyc);
        logic seen;
        seen = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                seen   = 1'b1;
                at_cyc = cyc;
            end
        end
        check("resp_valid_seen", 64'(seen), 64'd1);
    endtask

    task automatic wait_resps(input int target);
        for (int i = 0; i < 100 && n_resp < target; i++) @(negedge clk);
        check("resp_count", 64'(n_resp), 64'(target));
    endtask

    initial begin
        int acc, acc1, at, base, stable;
        logic [1:0]  h_type;
        logic [15:0] h_id;
        logic [63:0] h_pay;

        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_type    = '0;
        req_address = '0;
        req_bus_id  = '0;
        resp_ready  = 1'b1;
        load_en     = 1'b0;
        load_index  = '0;
        load_data   = '0;

        #3;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_fields", {resp_payload[47:0], resp_bus_id} ^ 64'(resp_type), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);

        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        for (int i = 5; i <= 7; i++) begin
            load_en    = 1'b1;
            load_index = 10'(i);
            load_data  = (i == 5) ? W5 : (i == 6) ? W6 : W7;
            @(posedge clk);
            #1;
        end
        load_en = 1'b0;
        check("idle_req_ready", 64'(req_ready), 64'd1);

        // Single read: aligned address, latency from idle.
        issue(bus_read_request, 64'h28, create_bus_id(8'h01, COMPONENT_TYPE_FETCH),
              bus_read_response, W5, acc);
        req_valid = 1'b0;
        wait_valid(at);
        check("idle_latency", 64'(at - acc), 64'(LAT));
        wait_resps(1);

        // Low three address bits are ignored.
        issue(bus_read_request, 64'h2D, 16'h0101, bus_read_response, W5, acc);
        req_valid = 1'b0;
        wait_resps(2);

        // Three back-to-back reads: queue fills, responses LATENCY+1 apart.
        base = n_resp;
        issue(bus_read_request, 64'h28, 16'h0102, bus_read_response, W5, acc1);
        issue(bus_read_request, 64'h30, 16'h0103, bus_read_response, W6, acc);
        issue(bus_read_request, 64'h38, 16'h0104, bus_read_response, W7, acc);
        check("full_req_ready", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        wait_resps(base + 3);
        if (n_resp >= base + 3) begin
            check("b2b_first_latency", 64'(resp_cyc[base] - acc1), 64'(LAT));
            check("b2b_gap1", 64'(resp_cyc[base+1] - resp_cyc[base]), 64'(LAT + 1));
            check("b2b_gap2", 64'(resp_cyc[base+2] - resp_cyc[base+1]), 64'(LAT + 1));
        end

        // Backpressure: response held stable, queued request served after release.
        base = n_resp;
        resp_ready = 1'b0;
        issue(bus_read_request, 64'h30, 16'h0201, bus_read_response, W6, acc);
        issue(bus_read_request, 64'h38, 16'h0202, bus_read_response, W7, acc);
        req_valid = 1'b0;
        wait_valid(at);
        h_type = resp_type;
        h_id   = resp_bus_id;
        h_pay  = resp_payload;
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid && resp_type === h_type && resp_bus_id === h_id && resp_payload === h_pay)
                stable++;
        end
        check("hold_stable_cycles", 64'(stable), 64'd10);
        check("hold_id", 64'(h_id), 64'h0201);
        resp_ready = 1'b1;
        wait_resps(base + 2);

        // Out-of-range index gives an error response.
        issue(bus_read_request, 64'h2000, 16'h0301, bus_error_response, 64'd0, acc);
        req_valid = 1'b0;
        wait_resps(base + 3);
        check("err_count_range", 64'(err_count), 64'd1);

        // Write request gives an error response.
        issue(bus_write_request, 64'h28, 16'h0302, bus_error_response, 64'd0, acc);
        req_valid = 1'b0;
        wait_resps(base + 4);
        check("err_count_write", 64'(err_count), 64'd2);

        // Reset during the access drops it without a response.
        base = n_resp;
        issue(bus_read_request, 64'h28, 16'h0303, bus_read_response, W5, acc);
        req_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check("midrst_req_ready", 64'(req_ready), 64'd0);
        check("midrst_fields", resp_payload | 64'(resp_bus_id) | 64'(resp_type) | 64'(err_count), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_no_resp", 64'(n_resp - base), 64'd0);

        issue(bus_read_request, 64'h30, 16'h0401, bus_read_response, W6, acc);
        req_valid = 1'b0;
        wait_valid(at);
        check("post_rst_latency", 64'(at - acc), 64'(LAT));
        wait_resps(base + 1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
